movimm_split: RTL and testbench

- Constant-load sequencer; the producer side of the MOV datapath unit.
- Takes a full 64-bit immediate plus a destination register index.
- Emits the MOVZ/MOVK piece sequence that the MOV unit consumes to rebuild that value: 16-bit immediate, movop and pre-shifted extended word per piece.
- Sits between the pseudo-instruction expander (LDI-style constant loads) and the execute-stage MOV path.

---
 rtl/movimm_split_if.sv | 43 ++++
 rtl/movimm_split.sv | 144 ++++++++++++++
 tb/tb_movimm_split.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/movimm_split_if.sv
// Load-request and piece-output handshake bundle for movimm_split.
// Supplies default `WORDSIZE / `MOVOPSIZE / `MOVSHIFTxx when bus.vh / movop.vh are absent.
`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef MOVOPSIZE
`define MOVOPSIZE 3
`endif
`ifndef MOVSHIFT00
`define MOVSHIFT00 2'd0
`define MOVSHIFT16 2'd1
`define MOVSHIFT32 2'd2
`define MOVSHIFT48 2'd3
`endif

interface movimm_split_if #(
    parameter int unsigned RDW = 5
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic [`WORDSIZE-1:0]  ld_value;
    logic [RDW-1:0]        ld_rd;

    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_imm16;
    logic [`MOVOPSIZE-1:0] out_movop;
    logic [`WORDSIZE-1:0]  out_extended;
    logic [RDW-1:0]        out_rd;
    logic                  out_last;

    // Sequencer side: consumes load requests, produces pieces.
    modport slave (
        input  ld_valid, ld_value, ld_rd, out_ready,
        output ld_ready, out_valid, out_imm16, out_movop, out_extended, out_rd, out_last
    );

    // Requester / consumer side.
    modport master (
        output ld_valid, ld_value, ld_rd, out_ready,
        input  ld_ready, out_valid, out_imm16, out_movop, out_extended, out_rd, out_last
    );
endinterface

// File: rtl/movimm_split.sv
// Splits a 64-bit constant into a MOVZ/MOVK piece sequence (ascending halfwords, zeros skipped).
// `define MOVSPLIT_FIXED_EN to always emit four pieces (shift 0,16,32,48) with no zero-skipping.
`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef MOVOPSIZE
`define MOVOPSIZE 3
`endif

module movimm_split #(
    parameter int unsigned RDW = 5
) (
    input logic           clk,
    input logic           rst_n,
    movimm_split_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_EMIT
    } state_e;

    state_e                state_q;
    logic                  ld_ready_q;
    logic [`WORDSIZE-1:0]  value_q;
    logic [3:0]            rem_q;
    logic                  out_valid_q;
    logic [15:0]           out_imm16_q;
    logic [`MOVOPSIZE-1:0] out_movop_q;
    logic [`WORDSIZE-1:0]  out_extended_q;
    logic [RDW-1:0]        out_rd_q;
    logic                  out_last_q;

    logic [3:0]  nz_mask;
    logic [1:0]  acc_idx_d;
    logic [3:0]  acc_rem_d;
    logic [15:0] acc_imm_d;
    logic [1:0]  nxt_idx_d;
    logic [3:0]  nxt_rem_d;
    logic [15:0] nxt_imm_d;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (m[i-1]) idx = 2'(i - 1);
        end
        return idx;
    endfunction

    function automatic logic [15:0] halfword(input logic [`WORDSIZE-1:0] v, input logic [1:0] idx);
        logic [15:0] h;
        case (idx)
            2'd0:    h = v[15:0];
            2'd1:    h = v[31:16];
            2'd2:    h = v[47:32];
            default: h = v[63:48];
        endcase
        return h;
    endfunction

    function automatic logic [`WORDSIZE-1:0] extend(input logic [15:0] imm, input logic [1:0] idx);
        logic [`WORDSIZE-1:0] e;
        e = '0;
        e[15:0] = imm;
        return e << {idx, 4'b0000};
    endfunction

    // A zero mask still yields one piece: lowest_set(0) = 0 with nothing remaining.
    always_comb begin
`ifdef MOVSPLIT_FIXED_EN
        nz_mask = 4'b1111;
`else
        nz_mask = {|bus.ld_value[63:48], |bus.ld_value[47:32],
                   |bus.ld_value[31:16], |bus.ld_value[15:0]};
`endif
        acc_idx_d = lowest_set(nz_mask);
        acc_rem_d = nz_mask & ~(4'b0001 << acc_idx_d);
        acc_imm_d = halfword(bus.ld_value, acc_idx_d);

        nxt_idx_d = lowest_set(rem_q);
        nxt_rem_d = rem_q & ~(4'b0001 << nxt_idx_d);
        nxt_imm_d = halfword(value_q, nxt_idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ld_ready_q     <= 1'b0;
            value_q        <= '0;
            rem_q          <= '0;
            out_valid_q    <= 1'b0;
            out_imm16_q    <= '0;
            out_movop_q    <= '0;
            out_extended_q <= '0;
            out_rd_q       <= '0;
            out_last_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ld_valid && ld_ready_q) begin
                        value_q        <= bus.ld_value;
                        rem_q          <= acc_rem_d;
                        out_valid_q    <= 1'b1;
                        out_imm16_q    <= acc_imm_d;
                        out_movop_q    <= {1'b0, acc_idx_d};
                        out_extended_q <= extend(acc_imm_d, acc_idx_d);
                        out_rd_q       <= bus.ld_rd;
                        out_last_q     <= (acc_rem_d == 4'b0000);
                        ld_ready_q     <= 1'b0;
                        state_q        <= ST_EMIT;
                    end else begin
                        ld_ready_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            ld_ready_q  <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            rem_q          <= nxt_rem_d;
                            out_imm16_q    <= nxt_imm_d;
                            out_movop_q    <= {1'b1, nxt_idx_d};
                            out_extended_q <= extend(nxt_imm_d, nxt_idx_d);
                            out_last_q     <= (nxt_rem_d == 4'b0000);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ld_ready     = ld_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_imm16    = out_imm16_q;
    assign bus.out_movop    = out_movop_q;
    assign bus.out_extended = out_extended_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_last     = out_last_q;

endmodule

// File: tb/tb_movimm_split.sv
// Directed table-driven bench for movimm_split; expectations follow MOVSPLIT_FIXED_EN when defined.
module tb_movimm_split;

    localparam int unsigned RDW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    movimm_split_if #(.RDW(RDW)) bus ();
    movimm_split #(.RDW(RDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [63:0]      value;
        logic [RDW-1:0]   rd;
        int unsigned      n;
        logic [3:0][15:0] imm;
        logic [3:0][2:0]  op;
        logic [15:0]      pat;
    } vec_t;

    vec_t vecs[6];
    vec_t v7;

    function automatic vec_t mk(input logic [63:0] value, input logic [RDW-1:0] rd,
                                input int unsigned n, input logic [15:0] pat,
                                input logic [15:0] i0, input logic [2:0] o0,
                                input logic [15:0] i1, input logic [2:0] o1,
                                input logic [15:0] i2, input logic [2:0] o2,
                                input logic [15:0] i3, input logic [2:0] o3);
        vec_t v;
        v.value = value; v.rd = rd; v.n = n; v.pat = pat;
        v.imm[0] = i0; v.op[0] = o0;
        v.imm[1] = i1; v.op[1] = o1;
        v.imm[2] = i2; v.op[2] = o2;
        v.imm[3] = i3; v.op[3] = o3;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_load(input vec_t v);
        int unsigned cyc;
        int unsigned p;
        logic [63:0] ext;
        logic        rdy;
        cyc = 0;
        while (!bus.ld_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ld_ready_idle", 64'(bus.ld_ready), 64'd1);
        bus.ld_valid = 1'b1;
        bus.ld_value = v.value;
        bus.ld_rd    = v.rd;
        @(negedge clk);
        // Scramble the request after accept so unlatched use of ld_value/ld_rd shows up.
        bus.ld_valid = 1'b0;
        bus.ld_value = ~v.value;
        bus.ld_rd    = ~v.rd;
        check("ld_ready_busy", 64'(bus.ld_ready), 64'd0);
        cyc = 0;
        p = 0;
        while (p < v.n && cyc < 40) begin
            ext = 64'(v.imm[p]) << (16 * v.op[p][1:0]);
            check("out_valid", 64'(bus.out_valid), 64'd1);
            check("out_imm16", 64'(bus.out_imm16), 64'(v.imm[p]));
            check("out_movop", 64'(bus.out_movop), 64'(v.op[p]));
            check("out_extended", bus.out_extended, ext);
            check("out_rd", 64'(bus.out_rd), 64'(v.rd));
            check("out_last", 64'(bus.out_last), 64'(p == v.n - 1));
            rdy = v.pat[cyc % 16];
            bus.out_ready = rdy;
            @(negedge clk);
            if (rdy) p++;
            cyc++;
        end
        check("piece_count", 64'(p), 64'(v.n));
        bus.out_ready = 1'b1;
        check("out_valid_done", 64'(bus.out_valid), 64'd0);
        check("ld_ready_done", 64'(bus.ld_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
`ifdef MOVSPLIT_FIXED_EN
        vecs[0] = mk(64'h0000_0000_0000_0000, 5'd3, 4, 16'hFFFF,
                     16'h0000, 3'b000, 16'h0000, 3'b101, 16'h0000, 3'b110, 16'h0000, 3'b111);
        vecs[1] = mk(64'h1234_0000_0000_ABCD, 5'd5, 4, 16'hFFFF,
                     16'hABCD, 3'b000, 16'h0000, 3'b101, 16'h0000, 3'b110, 16'h1234, 3'b111);
        vecs[3] = mk(64'h0000_0042_0000_0000, 5'd1, 4, 16'hFFFF,
                     16'h0000, 3'b000, 16'h0000, 3'b101, 16'h0042, 3'b110, 16'h0000, 3'b111);
        vecs[5] = mk(64'h8000_0000_0000_0001, 5'd0, 4, 16'hFFFF,
                     16'h0001, 3'b000, 16'h0000, 3'b101, 16'h0000, 3'b110, 16'h8000, 3'b111);
        v7      = mk(64'h0000_0000_0000_0007, 5'd12, 4, 16'hFFFF,
                     16'h0007, 3'b000, 16'h0000, 3'b101, 16'h0000, 3'b110, 16'h0000, 3'b111);
`else
        vecs[0] = mk(64'h0000_0000_0000_0000, 5'd3, 1, 16'hFFFF,
                     16'h0000, 3'b000, 16'h0, 3'b0, 16'h0, 3'b0, 16'h0, 3'b0);
        vecs[1] = mk(64'h1234_0000_0000_ABCD, 5'd5, 2, 16'hFFFF,
                     16'hABCD, 3'b000, 16'h1234, 3'b111, 16'h0, 3'b0, 16'h0, 3'b0);
        vecs[3] = mk(64'h0000_0042_0000_0000, 5'd1, 1, 16'hFFFF,
                     16'h0042, 3'b010, 16'h0, 3'b0, 16'h0, 3'b0, 16'h0, 3'b0);
        vecs[5] = mk(64'h8000_0000_0000_0001, 5'd0, 2, 16'hFFFF,
                     16'h0001, 3'b000, 16'h8000, 3'b111, 16'h0, 3'b0, 16'h0, 3'b0);
        v7      = mk(64'h0000_0000_0000_0007, 5'd12, 1, 16'hFFFF,
                     16'h0007, 3'b000, 16'h0, 3'b0, 16'h0, 3'b0, 16'h0, 3'b0);
`endif
        // out_ready sequence 1,0,0,1,0,1,1 then held high.
        vecs[2] = mk(64'hDEAD_BEEF_CAFE_F00D, 5'd7, 4, 16'hFFE9,
                     16'hF00D, 3'b000, 16'hCAFE, 3'b101, 16'hBEEF, 3'b110, 16'hDEAD, 3'b111);
        vecs[4] = mk(64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 4, 16'hFFFF,
                     16'hFFFF, 3'b000, 16'hFFFF, 3'b101, 16'hFFFF, 3'b110, 16'hFFFF, 3'b111);

        bus.ld_valid  = 1'b0;
        bus.ld_value  = '0;
        bus.ld_rd     = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        check("rst_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_imm16", 64'(bus.out_imm16), 64'd0);
        check("rst_out_movop", 64'(bus.out_movop), 64'd0);
        check("rst_out_extended", bus.out_extended, 64'd0);
        check("rst_out_rd", 64'(bus.out_rd), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        rst_n = 1'b1;
        #1 check("ld_ready_pre_clk", 64'(bus.ld_ready), 64'd0);
        @(negedge clk);
        check("ld_ready_post_rst", 64'(bus.ld_ready), 64'd1);

        for (int i = 0; i < 6; i++) run_load(vecs[i]);

        // Reset mid-sequence: first piece of the 4-piece load transfers, then rst_n pulses.
        bus.ld_valid = 1'b1;
        bus.ld_value = 64'hDEAD_BEEF_CAFE_F00D;
        bus.ld_rd    = 5'd7;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        check("mid_first_imm", 64'(bus.out_imm16), 64'hF00D);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mid_second_imm", 64'(bus.out_imm16), 64'hCAFE);
        check("mid_second_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_ld_ready", 64'(bus.ld_ready), 64'd0);
        check("mid_rst_imm", 64'(bus.out_imm16), 64'd0);
        check("mid_rst_last", 64'(bus.out_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mid_rel_ld_ready", 64'(bus.ld_ready), 64'd1);
        check("mid_rel_valid", 64'(bus.out_valid), 64'd0);
        run_load(v7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
